// File: rtl/contador_param_rco_pkg.sv
// Shared encodings for the parametrised counter: mode codes and the rco
// pulse FSM states.
package contador_param_rco_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_DNF  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } rco_state_e;

endpackage

// File: rtl/contador_param_rco_stretch.sv
// Stretches single-cycle wrap events into an rco pulse RCO_LEN cycles long;
// a wrap arriving mid-pulse restarts the stretch from the full length.
module rco_stretch
  import contador_param_rco_pkg::*;
#(
  parameter int RCO_LEN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic wrap,
  output logic rco
);

  localparam int CW = (RCO_LEN > 1) ? $clog2(RCO_LEN) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(RCO_LEN - 1);

  rco_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rco_q, rco_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wrap) begin
          state_d = PULSE;
          cnt_d   = RELOAD;
        end
      end
      PULSE: begin
        if (wrap) begin
          cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    rco_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rco_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rco_q   <= rco_d;
    end
  end

  assign rco = rco_q;

endmodule

// File: rtl/contador_param_rco.sv
// Parametrised four-mode counter with run-time modulus (limit+1), clamped
// parallel load, load strobe and a stretched ripple-carry/borrow pulse.
module contador_param_rco
  import contador_param_rco_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_FAST = 3,
  parameter int RCO_LEN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP_FAST);

  logic [WIDTH-1:0] q_q, q_d;
  logic             load_q, load_d;
  logic             wrap;
  logic [WIDTH-1:0] dn1_val;
  logic             dn1_wrap;

  always_comb begin
    q_d      = q_q;
    load_d   = 1'b0;
    wrap     = 1'b0;
    dn1_wrap = (q_q == '0);
    dn1_val  = dn1_wrap ? limit : q_q - WIDTH'(1);
    if (enable) begin
      case (mode)
        MODE_UP: begin
          // >= so a Q stranded above a freshly lowered limit wraps at once
          if (q_q >= limit) begin
            q_d  = '0;
            wrap = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        MODE_DN1: begin
          q_d  = dn1_val;
          wrap = dn1_wrap;
        end
        MODE_DNF: begin
          if (limit < STEP_W) begin
            q_d  = dn1_val;
            wrap = dn1_wrap;
          end else if (q_q >= STEP_W) begin
            q_d = q_q - STEP_W;
          end else begin
            // Q + (limit+1) - STEP taken mod 2^WIDTH; the carry out is discarded
            q_d  = q_q + limit + WIDTH'(1) - STEP_W;
            wrap = 1'b1;
          end
        end
        MODE_LOAD: begin
          q_d    = (D <= limit) ? D : limit;
          load_d = 1'b1;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      load_q <= load_d;
    end
  end

  rco_stretch #(.RCO_LEN(RCO_LEN)) u_rco (
    .clk   (clk),
    .reset (reset),
    .wrap  (wrap),
    .rco   (rco)
  );

  assign Q    = q_q;
  assign load = load_q;

endmodule

// File: tb/tb_contador_param_rco.sv
// Scoreboard bench for contador_param_rco: a default instance (RCO_LEN=1)
// plus an RCO_LEN=4 instance sharing the same stimulus for stretch checks.
module tb_contador_param_rco;
  import contador_param_rco_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic        rco;
    logic        load;
    logic        rco4;
    bit          chk4;
  } exp_t;

  typedef struct {
    bit          en;
    logic [1:0]  md;
    logic [31:0] d;
    logic [31:0] lim;
    logic [31:0] q;
    logic        r;
    logic        ld;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] D, limit;
  logic [31:0] Q, Q4;
  logic        rco, rco4, load, load4;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  contador_param_rco #(.WIDTH(32), .STEP_FAST(3), .RCO_LEN(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
    .limit(limit), .Q(Q), .rco(rco), .load(load)
  );

  contador_param_rco #(.WIDTH(32), .STEP_FAST(3), .RCO_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
    .limit(limit), .Q(Q4), .rco(rco4), .load(load4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic drive(input step_t s);
    enable = s.en;
    mode   = s.md;
    D      = s.d;
    limit  = s.lim;
  endtask

  task automatic test_reset();
    exp_t ex;
    checks++;
    if ({Q, rco, load, Q4, rco4, load4} !== 68'd0) begin
      errors++;
      $display("FAIL reset_hold: Q=%h rco=%b load=%b, expected all zero", Q, rco, load);
    end
    reset = 1'b1; enable = 1'b1; mode = MODE_DN1; limit = 32'h1234;
    sb.push_back('{32'h1234, 1'b1, 1'b0, 1'b1, 1'b1});
    tick();
    ex = sb.pop_front();
    checks++;
    if (Q !== ex.q || rco !== ex.rco || load !== ex.load || rco4 !== ex.rco4) begin
      errors++;
      $display("FAIL reset_pre: Q=%h rco=%b load=%b rco4=%b, expected Q=%h rco=%b load=%b rco4=%b",
               Q, rco, load, rco4, ex.q, ex.rco, ex.load, ex.rco4);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({Q, rco, load, Q4, rco4, load4} !== 68'd0) begin
      errors++;
      $display("FAIL reset_async: Q=%h rco=%b load=%b rco4=%b, expected all zero", Q, rco, load, rco4);
    end
    #1;
    reset = 1'b1;
    mode  = MODE_UP;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{32'(i), 1'b0, 1'b0, 1'b0, 1'b0});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load) begin
        errors++;
        $display("FAIL reset_count[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                 i, Q, rco, load, ex.q, ex.rco, ex.load);
      end
    end
  endtask

  task automatic test_up_wrap();
    exp_t ex;
    do_reset();
    enable = 1'b1; mode = MODE_UP; limit = 32'd9;
    checks++;
    if (Q !== 32'd0) begin
      errors++;
      $display("FAIL up_start: Q=%h, expected Q=0", Q);
    end
    for (int i = 1; i <= 11; i++) begin
      sb.push_back('{32'(i % 10), (i == 10), 1'b0, 1'b0, 1'b0});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load) begin
        errors++;
        $display("FAIL up_wrap[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                 i, Q, rco, load, ex.q, ex.rco, ex.load);
      end
    end
  endtask

  task automatic test_fast_down();
    exp_t ex;
    step_t st[7] = '{
      '{1'b1, MODE_LOAD, 32'd4, 32'd9, 32'd4, 1'b0, 1'b1},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd1, 1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd8, 1'b1, 1'b0},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd5, 1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd2, 1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd9, 1'b1, 1'b0},
      '{1'b1, MODE_DNF,  32'd0, 32'd9, 32'd6, 1'b0, 1'b0}
    };
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back('{st[i].q, st[i].r, st[i].ld, 1'b0, 1'b0});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load) begin
        errors++;
        $display("FAIL fast_down[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                 i, Q, rco, load, ex.q, ex.rco, ex.load);
      end
    end
  endtask

  task automatic test_load_clamp();
    exp_t ex;
    step_t st[7] = '{
      '{1'b1, MODE_LOAD, 32'd250, 32'd100, 32'd100, 1'b0, 1'b1},
      '{1'b0, MODE_LOAD, 32'd250, 32'd100, 32'd100, 1'b0, 1'b0},
      '{1'b0, MODE_UP,   32'd250, 32'd100, 32'd100, 1'b0, 1'b0},
      '{1'b0, MODE_DNF,  32'd250, 32'd100, 32'd100, 1'b0, 1'b0},
      '{1'b1, MODE_LOAD, 32'd57,  32'd100, 32'd57,  1'b0, 1'b1},
      '{1'b1, MODE_LOAD, 32'd100, 32'd100, 32'd100, 1'b0, 1'b1},
      '{1'b0, MODE_LOAD, 32'd3,   32'd100, 32'd100, 1'b0, 1'b0}
    };
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back('{st[i].q, st[i].r, st[i].ld, 1'b0, 1'b0});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load) begin
        errors++;
        $display("FAIL load_clamp[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                 i, Q, rco, load, ex.q, ex.rco, ex.load);
      end
    end
  endtask

  task automatic test_stretch();
    exp_t ex;
    do_reset();
    enable = 1'b1; mode = MODE_UP; limit = 32'd1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 9) enable = 1'b0;
      if (i <= 8) sb.push_back('{32'(i % 2), (i % 2 == 0), 1'b0, (i >= 2), 1'b1});
      else        sb.push_back('{32'd0, 1'b0, 1'b0, (i <= 11), 1'b1});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load ||
          Q4 !== ex.q || rco4 !== ex.rco4 || load4 !== ex.load) begin
        errors++;
        $display("FAIL stretch[%0d]: Q=%h rco=%b Q4=%h rco4=%b load4=%b, expected Q=%h rco=%b rco4=%b",
                 i, Q, rco, Q4, rco4, load4, ex.q, ex.rco, ex.rco4);
      end
    end
  endtask

  task automatic test_limit_edges();
    exp_t ex;
    step_t st[15] = '{
      '{1'b1, MODE_LOAD, 32'd30,        32'd50,        32'd30,        1'b0, 1'b1},
      '{1'b1, MODE_UP,   32'd0,         32'd10,        32'd0,         1'b1, 1'b0},
      '{1'b1, MODE_UP,   32'd0,         32'd10,        32'd1,         1'b0, 1'b0},
      '{1'b1, MODE_LOAD, 32'd2,         32'd2,         32'd2,         1'b0, 1'b1},
      '{1'b1, MODE_DNF,  32'd0,         32'd2,         32'd1,         1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0,         32'd2,         32'd0,         1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0,         32'd2,         32'd2,         1'b1, 1'b0},
      '{1'b1, MODE_DNF,  32'd0,         32'd2,         32'd1,         1'b0, 1'b0},
      '{1'b1, MODE_LOAD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1},
      '{1'b1, MODE_UP,   32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{1'b1, MODE_UP,   32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0},
      '{1'b1, MODE_UP,   32'd0,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0},
      '{1'b1, MODE_DNF,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0},
      '{1'b1, MODE_DNF,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0},
      '{1'b0, MODE_DNF,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0}
    };
    do_reset();
    enable = 1'b1; mode = MODE_DN1; limit = 32'd0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'd0, 1'b1, 1'b0, 1'b1, 1'b1});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load || Q4 !== ex.q || rco4 !== ex.rco4) begin
        errors++;
        $display("FAIL limit_zero[%0d]: Q=%h rco=%b Q4=%h rco4=%b, expected Q=0 rco=1 rco4=1",
                 i, Q, rco, Q4, rco4);
      end
    end
    for (int i = 0; i < 15; i++) begin
      drive(st[i]);
      sb.push_back('{st[i].q, st[i].r, st[i].ld, 1'b0, 1'b0});
      tick();
      ex = sb.pop_front();
      checks++;
      if (Q !== ex.q || rco !== ex.rco || load !== ex.load) begin
        errors++;
        $display("FAIL limit_edge[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                 i, Q, rco, load, ex.q, ex.rco, ex.load);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; mode = MODE_UP; D = '0; limit = '0;
    #3;
    test_reset();
    test_up_wrap();
    test_fast_down();
    test_load_clamp();
    test_stretch();
    test_limit_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_param_rco.md
Name: contador_param_rco

Overview:
- Parametrised successor to the fixed 32-bit four-mode counter.
- Generalises counter width, the fast down-step and a run-time modulus (`limit`).
- Adds a stretched `rco` pulse of programmable length, produced by a small pulse FSM.
- Sits wherever the fixed counter is instantiated. It is also chainable: `rco` of one stage drives `enable` of the next.

Parameters:
- WIDTH, 32, counter width in bits (Q, D, limit).
- STEP_FAST, 3, decrement amount in mode 2'b10 (1 ≤ STEP_FAST < 2^WIDTH).
- RCO_LEN, 1, number of clk cycles `rco` stays high per wrap event (≥1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count/load qualifier; 0 = hold Q.
- mode  input  2  00 up +1, 01 down −1, 10 down −STEP_FAST, 11 parallel load D.
- D  input  WIDTH  parallel load value.
- limit  input  WIDTH  terminal count; modulus M = limit+1.
- Q  output  WIDTH  registered count.
- rco  output  1  registered ripple-carry/borrow pulse, stretched to RCO_LEN cycles.
- load  output  1  registered; high one cycle after an accepted load.

Behaviour:
- Reset (reset=0, asynchronous): Q=0, rco=0, load=0, pulse FSM to IDLE, stretch counter=0. On release, normal operation starts at the first rising edge.
- All outputs are registered. The effect of inputs sampled at edge k is visible after edge k.
- enable=0: Q holds and load=0. The `rco` stretch still runs to completion.
- Mode 00, up:
  - Q<limit → Q+1, no wrap.
  - Q≥limit → Q=0 and a wrap event. This includes Q>limit after a run-time change of `limit`.
- Mode 01, down by 1:
  - Q>0 → Q−1.
  - Q=0 → Q=limit and a wrap event.
- Mode 10, down by STEP_FAST:
  - Q≥STEP_FAST → Q−STEP_FAST.
  - Otherwise → Q = Q+M−STEP_FAST and a wrap event. Compute in WIDTH+1 bits; the result is taken mod 2^WIDTH.
  - If limit<STEP_FAST, mode 10 behaves exactly as mode 01.
- Mode 11, load:
  - Q = D if D≤limit, else Q = limit (clamp).
  - load=1 for one cycle. No wrap event.
- load=0 in every cycle without an accepted load.
- Pulse FSM (states IDLE, PULSE):
  - IDLE + wrap event → PULSE; rco=1; stretch counter=RCO_LEN−1.
  - PULSE: if the counter is 0 and there is no new wrap → IDLE, rco=0. Otherwise decrement the counter.
  - PULSE + new wrap event → counter reloads to RCO_LEN−1 (restart, not extend-add); rco stays 1.
  - With RCO_LEN=1, consecutive wraps give continuous rco=1.
- Width rules:
  - All comparisons are unsigned.
  - limit=0 gives M=1: modes 00/01/10 keep Q=0 and wrap every enabled cycle.
  - limit=2^WIDTH−1 gives natural binary wrap.
- Reset mid-pulse clears rco immediately; there is no residual pulse after release.
- Mode changes take effect on the very next edge; there is no pipeline.

Decomposition:
- Shared package holds the mode encoding constants (MODE_UP=2'b00, MODE_DN1=2'b01, MODE_DNF=2'b10, MODE_LOAD=2'b11) and the FSM state encoding (IDLE, PULSE).
- One natural sub-module, rco_stretch:
  - Parameter RCO_LEN.
  - Inputs clk, reset, wrap.
  - Output rco.
  - Contains the FSM and stretch counter.
- The counter datapath stays in the top module.

Test Plan:
- Reset behaviour: assert reset=0 mid-count with Q=0x1234 and rco high → Q=0, rco=0, load=0 asynchronously, without waiting for a clk edge; after release and mode 00, Q counts 1, 2, 3.
- Up wrap: WIDTH=32, limit=9, mode 00, Q from 0 for 12 cycles → Q reads 0..9, 0, 1; with RCO_LEN=1, rco=1 only in the cycle Q=0 after 9.
- Fast down wrap: limit=9, load D=4, then mode 10 → Q=4, 1, 8, 5, 2, 9; rco=1 coincident with Q=8 and Q=9.
- Load clamp and load flag: limit=100, mode 11, D=250 → Q=100, load=1 for exactly one cycle; then enable=0 for 3 cycles → Q stays 100, load=0.
- Stretch and retrigger: RCO_LEN=4, limit=1, mode 00 → wraps every 2 cycles, so rco stays continuously 1; then enable=0 → rco stays 1 for the remaining stretch count, then falls.
- Limit edge cases:
  - limit=0, mode 01 → Q=0 and rco=1 every enabled cycle.
  - limit reduced from 50 to 10 while Q=30, mode 00 → next Q=0 with a wrap event.
  - limit=2, mode 10 with STEP_FAST=3 → behaves as −1: Q=2, 1, 0, 2.
